// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM sequencing fetch, decode, execute, memory and writeback.
// Optional feature MC_RETIRE_CNT_EN adds the 32-bit `retired` instruction counter output.
module mc_ctrl_fsm #(
    parameter int STATE_W     = 4,
    parameter bit TRAP_STICKY = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Format,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         PCSource,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               ExtOp,
    output logic               illegal,
`ifdef MC_RETIRE_CNT_EN
    output logic [31:0]        retired,
`endif
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        IDLE   = STATE_W'(0),
        FETCH  = STATE_W'(1),
        DECODE = STATE_W'(2),
        MEMADR = STATE_W'(3),
        MEMRD  = STATE_W'(4),
        MEMWB  = STATE_W'(5),
        MEMWR  = STATE_W'(6),
        REXEC  = STATE_W'(7),
        RWB    = STATE_W'(8),
        BRANCH = STATE_W'(9),
        JUMP   = STATE_W'(10),
        JR     = STATE_W'(11),
        IEXEC  = STATE_W'(12),
        IWB    = STATE_W'(13),
        TRAP   = STATE_W'(14)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic [1:0] pc_source;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       illegal;
    } ctrl_t;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;

    function automatic logic rtype_ok(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_OR) ||
               (fn == FN_SLT) || (fn == FN_SLL) || (fn == FN_SRL);
    endfunction

    // Moore control word for a state; evaluated on the next state so the outputs come from flops.
    function automatic ctrl_t decode(input state_t s, input logic [5:0] fmt);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
                c.ext_op    = 1'b1;
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.ext_op    = 1'b1;
            end
            MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
            end
            MEMWR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            REXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b01;
            end
            IEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b11;
                c.ext_op    = !((fmt == OP_ANDI) || (fmt == OP_ORI));
            end
            IWB: begin
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_source = 2'b01;
            end
            JUMP: begin
                c.pc_source = 2'b10;
                if (fmt == OP_JAL) begin
                    c.reg_write  = 1'b1;
                    c.reg_dst    = 2'b10;
                    c.mem_to_reg = 2'b10;
                end
            end
            JR: begin
                c.pc_source = 2'b11;
            end
            TRAP: begin
                c.illegal = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  if (mem_ack) state_d = DECODE;
            DECODE: begin
                case (Format)
                    OP_RTYPE: begin
                        if (Funct == FN_JR)      state_d = JR;
                        else if (rtype_ok(Funct)) state_d = REXEC;
                        else                      state_d = TRAP;
                    end
                    OP_LW, OP_SW:   state_d = MEMADR;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_J, OP_JAL:   state_d = JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_d = IEXEC;
                    default:        state_d = TRAP;
                endcase
            end
            MEMADR: state_d = (Format == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ack) state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (mem_ack) state_d = FETCH;
            REXEC:  state_d = RWB;
            RWB:    state_d = FETCH;
            IEXEC:  state_d = IWB;
            IWB:    state_d = FETCH;
            BRANCH: state_d = FETCH;
            JUMP:   state_d = FETCH;
            JR:     state_d = FETCH;
            TRAP:   state_d = TRAP_STICKY ? TRAP : FETCH;
            default: state_d = TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
`ifdef MC_RETIRE_CNT_EN
            retired <= '0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d, Format);
`ifdef MC_RETIRE_CNT_EN
            if ((state_d == FETCH) &&
                (state_q inside {MEMWB, MEMWR, RWB, IWB, BRANCH, JUMP, JR}))
                retired <= retired + 32'd1;
`endif
        end
    end

    // Strobes are the only combinational outputs; masking them with reset keeps the reset cycle quiet.
    always_comb begin
        IRWrite = 1'b0;
        PCWrite = 1'b0;
        if (reset) begin
            case (state_q)
                FETCH: begin
                    IRWrite = mem_ack;
                    PCWrite = mem_ack;
                end
                BRANCH:  PCWrite = (Format == OP_BNE) ? !Zero : Zero;
                JUMP:    PCWrite = 1'b1;
                JR:      PCWrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_req  = ctrl_q.mem_req;
    assign mem_we   = ctrl_q.mem_we;
    assign IorD     = ctrl_q.iord;
    assign PCSource = ctrl_q.pc_source;
    assign RegWrite = ctrl_q.reg_write;
    assign RegDst   = ctrl_q.reg_dst;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign ALUSrcA  = ctrl_q.alu_src_a;
    assign ALUSrcB  = ctrl_q.alu_src_b;
    assign ALUOp    = ctrl_q.alu_op;
    assign ExtOp    = ctrl_q.ext_op;
    assign illegal  = ctrl_q.illegal;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed table of instructions with expected state paths and control words,
// plus hand-written sequences for reset, delayed acks and traps.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Format;
    logic [5:0]  Funct;
    logic        Zero;
    logic        mem_ack;
    logic        mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, ALUSrcA, ExtOp, illegal;
    logic [1:0]  PCSource, RegDst, MemtoReg, ALUSrcB, ALUOp;
    logic [3:0]  state;
`ifdef MC_RETIRE_CNT_EN
    logic [31:0] retired;
`endif
    logic [18:0] word;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.STATE_W(4), .TRAP_STICKY(1'b1)) dut (
        .clk(clk), .reset(reset), .Format(Format), .Funct(Funct), .Zero(Zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtOp(ExtOp),
        .illegal(illegal),
`ifdef MC_RETIRE_CNT_EN
        .retired(retired),
`endif
        .state(state)
    );

    assign word = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSource, RegWrite, RegDst,
                   MemtoReg, ALUSrcA, ALUSrcB, ALUOp, ExtOp, illegal};

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [18:0] cw(input logic req, input logic we, input logic iord,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
                                       input logic a, input logic [1:0] b, input logic [1:0] op,
                                       input logic ext, input logic ill);
        return {req, we, iord, irw, pcw, pcs, rw, rd, m2r, a, b, op, ext, ill};
    endfunction

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_state(input string name, input logic [3:0] exp);
        mid();
        chk(name, state, exp);
        fin();
    endtask

    typedef struct {
        logic [5:0]  fmt;
        logic [5:0]  fn;
        logic        zero;
        int unsigned len;
        logic [23:0] path;
        int unsigned kidx;
        logic [18:0] kword;
    } vec_t;

    localparam int unsigned NV = 23;
    vec_t vecs [NV];

    logic [18:0] w_trap;

    initial begin
        // fields: req we iord irw pcw pcs rw rd m2r a b op ext ill
        vecs[0]  = '{6'b100011, 6'b000000, 1'b0, 5, 24'h054321, 4, cw(0,0,0,0,0,2'b00,1,2'b00,2'b01,0,2'b00,2'b00,0,0)};
        vecs[1]  = '{6'b100011, 6'b000000, 1'b0, 5, 24'h054321, 3, cw(1,0,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,2'b00,0,0)};
        vecs[2]  = '{6'b100011, 6'b000000, 1'b0, 5, 24'h054321, 2, cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b10,2'b00,1,0)};
        vecs[3]  = '{6'b101011, 6'b000000, 1'b0, 4, 24'h006321, 3, cw(1,1,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,2'b00,0,0)};
        vecs[4]  = '{6'b000000, 6'b100000, 1'b0, 4, 24'h008721, 2, cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,2'b10,0,0)};
        vecs[5]  = '{6'b000000, 6'b101010, 1'b0, 4, 24'h008721, 3, cw(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,2'b00,0,0)};
        vecs[6]  = '{6'b001000, 6'b000000, 1'b0, 4, 24'h00DC21, 2, cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b10,2'b11,1,0)};
        vecs[7]  = '{6'b001101, 6'b000000, 1'b0, 4, 24'h00DC21, 2, cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b10,2'b11,0,0)};
        vecs[8]  = '{6'b001100, 6'b000000, 1'b0, 4, 24'h00DC21, 3, cw(0,0,0,0,0,2'b00,1,2'b00,2'b00,0,2'b00,2'b00,0,0)};
        vecs[9]  = '{6'b000100, 6'b000000, 1'b1, 3, 24'h000921, 2, cw(0,0,0,0,1,2'b01,0,2'b00,2'b00,1,2'b00,2'b01,0,0)};
        vecs[10] = '{6'b000101, 6'b000000, 1'b1, 3, 24'h000921, 2, cw(0,0,0,0,0,2'b01,0,2'b00,2'b00,1,2'b00,2'b01,0,0)};
        vecs[11] = '{6'b000101, 6'b000000, 1'b0, 3, 24'h000921, 2, cw(0,0,0,0,1,2'b01,0,2'b00,2'b00,1,2'b00,2'b01,0,0)};
        vecs[12] = '{6'b000100, 6'b000000, 1'b0, 3, 24'h000921, 2, cw(0,0,0,0,0,2'b01,0,2'b00,2'b00,1,2'b00,2'b01,0,0)};
        vecs[13] = '{6'b000010, 6'b000000, 1'b0, 3, 24'h000A21, 2, cw(0,0,0,0,1,2'b10,0,2'b00,2'b00,0,2'b00,2'b00,0,0)};
        vecs[14] = '{6'b000011, 6'b000000, 1'b0, 3, 24'h000A21, 2, cw(0,0,0,0,1,2'b10,1,2'b10,2'b10,0,2'b00,2'b00,0,0)};
        vecs[15] = '{6'b000000, 6'b001000, 1'b0, 3, 24'h000B21, 2, cw(0,0,0,0,1,2'b11,0,2'b00,2'b00,0,2'b00,2'b00,0,0)};
        vecs[16] = '{6'b001111, 6'b000000, 1'b0, 4, 24'h00DC21, 0, cw(1,0,0,1,1,2'b00,0,2'b00,2'b00,0,2'b01,2'b00,0,0)};
        vecs[17] = '{6'b001010, 6'b000000, 1'b0, 4, 24'h00DC21, 1, cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b11,2'b00,1,0)};
        vecs[18] = '{6'b000000, 6'b000000, 1'b0, 4, 24'h008721, 3, cw(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,2'b00,0,0)};
        vecs[19] = '{6'b000000, 6'b000010, 1'b0, 4, 24'h008721, 2, cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,2'b10,0,0)};
        vecs[20] = '{6'b000000, 6'b100010, 1'b0, 4, 24'h008721, 2, cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,2'b10,0,0)};
        vecs[21] = '{6'b000000, 6'b100100, 1'b0, 4, 24'h008721, 2, cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,2'b10,0,0)};
        vecs[22] = '{6'b000000, 6'b100101, 1'b0, 4, 24'h008721, 2, cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,2'b10,0,0)};
        w_trap   = cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,2'b00,0,1);

        // Reset held with ack high: everything quiet.
        reset = 1'b0; mem_ack = 1'b1; Format = 6'b100011; Funct = '0; Zero = 1'b0;
        fin();
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("reset_state", state, 4'd0);
            chk("reset_outputs", word, 19'd0);
            fin();
        end

        // Release; one IDLE cycle, then FETCH with the ack 3 cycles late.
        reset = 1'b1; mem_ack = 1'b0;
        cyc_state("idle_after_release", 4'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ack = 1'b1;
            mid();
            chk("fetch_wait_state", state, 4'd1);
            chk("fetch_wait_req", mem_req, 1'b1);
            chk("fetch_wait_irwrite", IRWrite, (i == 3) ? 1'b1 : 1'b0);
            chk("fetch_wait_pcwrite", PCWrite, (i == 3) ? 1'b1 : 1'b0);
            fin();
        end

        // lw continues with ack low outside memory states and a 2-cycle late MEMRD ack.
        mem_ack = 1'b0;
        cyc_state("dly_decode", 4'd2);
        cyc_state("dly_memadr", 4'd3);
        cyc_state("dly_memrd0", 4'd4);
        cyc_state("dly_memrd1", 4'd4);
        mem_ack = 1'b1;
        cyc_state("dly_memrd_ack", 4'd4);
        mem_ack = 1'b0;
        cyc_state("dly_memwb", 4'd5);
        mem_ack = 1'b1;

        for (int unsigned v = 0; v < NV; v++) begin
            Format = vecs[v].fmt;
            Funct  = vecs[v].fn;
            Zero   = vecs[v].zero;
            for (int unsigned i = 0; i < vecs[v].len; i++) begin
                mid();
                chk($sformatf("vec%0d_state%0d", v, i), state, vecs[v].path[4*i +: 4]);
                if (i == vecs[v].kidx)
                    chk($sformatf("vec%0d_ctrl", v), word, vecs[v].kword);
                fin();
            end
        end

        // sw with ack low outside FETCH/MEMWR, MEMWR waits two cycles.
        Format = 6'b101011; Funct = '0; mem_ack = 1'b1;
        cyc_state("sw_fetch", 4'd1);
        mem_ack = 1'b0;
        cyc_state("sw_decode", 4'd2);
        cyc_state("sw_memadr", 4'd3);
        cyc_state("sw_memwr0", 4'd6);
        mid();
        chk("sw_memwr_we", {mem_req, mem_we, IorD}, 3'b111);
        fin();
        mem_ack = 1'b1;
        cyc_state("sw_memwr_ack", 4'd6);
        mem_ack = 1'b0;
        mid();
        chk("fetch_noack_state", state, 4'd1);
        chk("fetch_noack_irwrite", IRWrite, 1'b0);
        fin();

        // Reset mid-fetch: strobes stay low, mem_req drops next cycle.
        reset = 1'b0; mem_ack = 1'b1;
        mid();
        chk("midreset_strobes", {IRWrite, PCWrite}, 2'b00);
        fin();
        reset = 1'b1;
        mid();
        chk("midreset_state", state, 4'd0);
        chk("midreset_outputs", word, 19'd0);
        fin();

        // Illegal opcode: sticky trap for 10 cycles, acks ignored.
        Format = 6'b111111;
        cyc_state("trap_fetch", 4'd1);
        cyc_state("trap_decode", 4'd2);
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("trap_state", state, 4'd14);
            chk("trap_outputs", word, w_trap);
            fin();
        end
        reset = 1'b0;
        mid();
        fin();
        reset = 1'b1;
        mid();
        chk("trap_reset_state", state, 4'd0);
        chk("trap_reset_outputs", word, 19'd0);
        fin();

        // Unsupported R-type funct also traps.
        Format = 6'b000000; Funct = 6'b000001;
        cyc_state("badfn_fetch", 4'd1);
        cyc_state("badfn_decode", 4'd2);
        mid();
        chk("badfn_state", state, 4'd14);
        chk("badfn_illegal", illegal, 1'b1);
        fin();
        cyc_state("badfn_sticky", 4'd14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control FSM for the MIPS core. It sequences fetch, decode, execute, memory and writeback using the Format/Funct fields from the instruction decoder. It drives the datapath write enables and mux selects, and handshakes with a variable-latency memory port. It sits between the IR/decoder and the PC, register file, ALU and memory muxes.

Parameters:
STATE_W, 4, width of the state register and the `state` debug port.
TRAP_STICKY, 1, 1 = the TRAP state is held until reset; 0 = TRAP returns to FETCH after one cycle.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset.
Format  in  6  opcode field instruction[31:26], from the decoder on IR.
Funct  in  6  function field instruction[5:0], from the decoder on IR.
Zero  in  1  ALU zero flag.
mem_ack  in  1  memory access complete this cycle.
mem_req  out  1  memory access request.
mem_we  out  1  request is a write.
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
IRWrite  out  1  load IR.
PCWrite  out  1  load PC.
PCSource  out  2  next-PC select: 00 = ALU, 01 = ALUOut (branch), 10 = jump target, 11 = Rs (jr).
RegWrite  out  1  register file write enable.
RegDst  out  2  destination select: 00 = Rt, 01 = Rd, 10 = $31.
MemtoReg  out  2  writeback select: 00 = ALUOut, 01 = MDR, 10 = PC.
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = Rs.
ALUSrcB  out  2  ALU B select: 00 = Rt, 01 = const 4, 10 = ext Imm16, 11 = ext Imm16 << 2.
ALUOp  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode Funct, 11 = decode Format (immediate ops).
ExtOp  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
illegal  out  1  unsupported opcode or funct trapped.
state  out  STATE_W  current state, for the debugger.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REXEC=7, RWB=8, BRANCH=9, JUMP=10, JR=11, IEXEC=12, IWB=13, TRAP=14.
- Outputs are Moore decodes of `state`. The only Mealy terms are IRWrite and PCWrite, which are qualified by mem_ack in FETCH.
- Reset:
  - reset=0 at a clock edge puts the state in IDLE. Every output is 0, and `state` reads 0.
  - Reset asserted mid-access drops mem_req the next cycle. No strobe fires in that cycle.
  - IDLE goes to FETCH unconditionally.
- FETCH:
  - mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - Holds until mem_ack. On the ack cycle: IRWrite=1, PCWrite=1, next state DECODE.
  - Exactly one IR/PC load per fetch, whatever the ack delay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00, ExtOp=1 (branch target into ALUOut). Dispatch on Format, which is valid from DECODE onward:
  - 000000: funct 001000 goes to JR; funct in {100000, 100010, 100100, 100101, 101010, 000000, 000010} goes to REXEC; any other funct goes to TRAP.
  - 100011 (lw) and 101011 (sw) go to MEMADR.
  - 000100 (beq) and 000101 (bne) go to BRANCH.
  - 000010 (j) and 000011 (jal) go to JUMP.
  - 001000, 001010, 001100, 001101, 001111 go to IEXEC.
  - Any other Format goes to TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtOp=1. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, IorD=1; holds until mem_ack, then MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01; then FETCH.
- MEMWR: mem_req=1, mem_we=1, IorD=1; holds until mem_ack, then FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; then RWB.
- RWB: RegWrite=1, RegDst=01, MemtoReg=00; then FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11. ExtOp=0 for andi/ori (001100, 001101), otherwise 1. Then IWB.
- IWB: RegWrite=1, RegDst=00, MemtoReg=00; then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. PCWrite = Zero for beq, !Zero for bne. Then FETCH.
- JUMP: PCSource=10, PCWrite=1. For jal only: RegWrite=1, RegDst=10, MemtoReg=10. Then FETCH.
- JR: PCSource=11, PCWrite=1; then FETCH.
- TRAP: illegal=1, all strobes 0. With TRAP_STICKY=1 it stays until reset; with 0 it returns to FETCH and illegal is a one-cycle pulse.
- mem_ack is ignored outside FETCH, MEMRD and MEMWR.
- State encodings 15 and above (unreachable) go to TRAP.
- Latency with immediate ack, counted from FETCH entry:
  - lw: 5 cycles.
  - sw, R-type, I-type: 4 cycles.
  - beq, bne, j, jal, jr: 3 cycles.

Optional Feature:
MC_RETIRE_CNT_EN:
- Defined: adds output `retired` [31:0].
  - Reset value 0.
  - Increments by 1 in the cycle the FSM leaves MEMWB, MEMWR (on ack), RWB, IWB, BRANCH, JUMP or JR toward FETCH.
  - Wraps from 0xFFFFFFFF to 0.
  - Not incremented by TRAP.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset test: hold reset=0 for 3 cycles with mem_ack=1. Required: all outputs 0 and state=0 throughout. After release: state=1 (FETCH) and mem_req=1.
- Delayed fetch ack: FETCH with mem_ack arriving 3 cycles late. Required: mem_req=1 for 4 cycles; IRWrite and PCWrite high only on the ack cycle; state=2 next.
- lw timing: Format=100011 with immediate acks. Required state sequence 1,2,3,4,5,1. In state 5: RegWrite=1, RegDst=00, MemtoReg=01.
- Branch, Zero=1: beq gives PCWrite=1, PCSource=01 in state 9. bne with the same Zero=1 gives PCWrite=0.
- jal and jr: Format=000011 gives, in state 10, PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. Format=000000 with Funct=001000 gives state 11, PCSource=11.
- Illegal opcode: Format=111111 with TRAP_STICKY=1. Required: state=14, illegal=1, no strobes for 10 cycles. Then reset=0 gives state=0.
